// File: rtl/wmst_arbiter_pkg.sv
// Shared accelerator constants for the write-master arbiter: FSM state
// encodings and a small helper for the round-robin pointer update.
package wmst_arbiter_pkg;

  // Arbiter FSM states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CONFIG = 2'b01,
    TRANS  = 2'b10,
    DONE   = 2'b11
  } wmst_state_t;

  localparam int NUM_REQ = 2;

  // After a transfer completes, priority moves to the requester that was not
  // served: a one-hot grant of 2'b01 (req0) hands priority to req1 (rr=1).
  function automatic logic next_rr(input logic [1:0] served);
    return served[0];
  endfunction

endpackage

// File: rtl/wmst_arbiter_rr_arb2.sv
// Two-input round-robin grant selector. The requester named by rr wins if it
// is pending, otherwise the other requester wins; no pending gives 2'b00.
module rr_arb2
  import wmst_arbiter_pkg::*;
(
  input  logic [1:0] pending,
  input  logic       rr,
  output logic [1:0] winner
);

  // Pick the one-hot winner from the pending bits and the priority pointer.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves winner
    // unassigned; otherwise synthesis infers a latch.
    winner = 2'b00;
    if (pending[rr]) begin
      winner[rr] = 1'b1;
    end else if (pending[~rr]) begin
      winner[~rr] = 1'b1;
    end
  end

endmodule

// File: rtl/wmst_arbiter.sv
// Write-master arbiter: shares one Avalon write master between two store
// controllers. Requests are captured into per-requester holding registers,
// then served one at a time in round-robin order through the sequence
// IDLE -> CONFIG -> TRANS -> DONE.
module wmst_arbiter
  import wmst_arbiter_pkg::*;
#(
  parameter int XAW = 32,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_start,
  input  logic           req1_start,
  input  logic [XAW-1:0] req0_waddr,
  input  logic [XAW-1:0] req1_waddr,
  input  logic [CW-1:0]  req0_iolen,
  input  logic [CW-1:0]  req1_iolen,
  output logic           req0_done,
  output logic           req1_done,
  output logic [1:0]     grant,
  output logic           trans_start,
  output logic [XAW-1:0] param_waddr,
  output logic [CW-1:0]  param_iolen,
  input  logic           trans_done,
  output logic           req_ovf
);

  wmst_state_t    state;
  logic [1:0]     pending;
  logic           rr;
  logic [1:0]     req_done;
  logic [XAW-1:0] hold_waddr [NUM_REQ];
  logic [CW-1:0]  hold_iolen [NUM_REQ];

  logic [1:0]     start;
  logic [1:0]     clr;
  logic [1:0]     accept;
  logic           ovf_hit;
  logic [1:0]     winner;
  logic           win_idx;

  assign start   = {req1_start, req0_start};
  // The granted requester's pending bit clears on the edge that leaves DONE.
  assign clr     = (state == DONE) ? grant : 2'b00;
  // A start is taken when nothing is pending, or when the bit clears on the
  // same edge (the new request wins over the clear).
  assign accept  = start & (~pending | clr);
  assign ovf_hit = |(start & pending & ~clr);

  assign req0_done = req_done[0];
  assign req1_done = req_done[1];

  rr_arb2 u_rr_arb2 (
    .pending (pending),
    .rr      (rr),
    .winner  (winner)
  );

  assign win_idx = winner[1];

  // Capture requests into pending bits and holding registers; flag overflow.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the holding registers are plain flops, not a RAM, so they are
    // reset along with everything else; a real memory array would not be.
    if (!rst) begin
      pending <= 2'b00;
      req_ovf <= 1'b0;
      for (int n = 0; n < NUM_REQ; n++) begin
        hold_waddr[n] <= '0;
        hold_iolen[n] <= '0;
      end
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // flop sees pre-edge values regardless of statement order.
      pending <= (pending & ~clr) | start;
      if (ovf_hit) begin
        req_ovf <= 1'b1;
      end
      if (accept[0]) begin
        hold_waddr[0] <= req0_waddr;
        hold_iolen[0] <= req0_iolen;
      end
      if (accept[1]) begin
        hold_waddr[1] <= req1_waddr;
        hold_iolen[1] <= req1_iolen;
      end
    end
  end

  // Transfer sequencing FSM with registered grant, parameters and pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr          <= 1'b0;
      grant       <= 2'b00;
      trans_start <= 1'b0;
      req_done    <= 2'b00;
      param_waddr <= '0;
      param_iolen <= '0;
    end else begin
      trans_start <= 1'b0;
      req_done    <= 2'b00;
      unique case (state)
        IDLE: begin
          if (|pending) begin
            state       <= CONFIG;
            grant       <= winner;
            param_waddr <= hold_waddr[win_idx];
            param_iolen <= hold_iolen[win_idx];
          end
        end
        CONFIG: begin
          state       <= TRANS;
          trans_start <= 1'b1;
        end
        TRANS: begin
          if (trans_done) begin
            state    <= DONE;
            req_done <= grant;
          end
        end
        DONE: begin
          state <= IDLE;
          rr    <= next_rr(grant);
          grant <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wmst_arbiter.sv
// Self-checking bench for wmst_arbiter: a directed vector table, hand-written
// corner sequences, and a randomized run against a transaction-level model.
module tb_wmst_arbiter;

  localparam int XAW = 32;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req0_start = 1'b0, req1_start = 1'b0;
  logic [XAW-1:0] req0_waddr = '0, req1_waddr = '0;
  logic [CW-1:0]  req0_iolen = '0, req1_iolen = '0;
  logic           req0_done, req1_done;
  logic [1:0]     grant;
  logic           trans_start;
  logic [XAW-1:0] param_waddr;
  logic [CW-1:0]  param_iolen;
  logic           trans_done = 1'b0;
  logic           req_ovf;

  int n_vec = 0;
  int n_err = 0;

  wmst_arbiter #(.XAW(XAW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_start  (req0_start),
    .req1_start  (req1_start),
    .req0_waddr  (req0_waddr),
    .req1_waddr  (req1_waddr),
    .req0_iolen  (req0_iolen),
    .req1_iolen  (req1_iolen),
    .req0_done   (req0_done),
    .req1_done   (req1_done),
    .grant       (grant),
    .trans_start (trans_start),
    .param_waddr (param_waddr),
    .param_iolen (param_iolen),
    .trans_done  (trans_done),
    .req_ovf     (req_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach its summary line");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Output bundle: {grant, trans_start, done[1:0], ovf, waddr, iolen}.
  function automatic logic [63:0] pack(input logic [1:0] g, input logic ts, input logic [1:0] d,
                                       input logic o, input logic [XAW-1:0] a, input logic [CW-1:0] l);
    return {10'd0, g, ts, d, o, a, l};
  endfunction

  function automatic logic [63:0] dut_out();
    return pack(grant, trans_start, {req1_done, req0_done}, req_ovf, param_waddr, param_iolen);
  endfunction

  // Drive one cycle of inputs at a falling edge, return at the next falling edge.
  task automatic step(input bit r, input bit [1:0] st, input logic [XAW-1:0] a0, input logic [CW-1:0] l0,
                      input logic [XAW-1:0] a1, input logic [CW-1:0] l1, input bit td);
    rst = r;
    {req1_start, req0_start} = st;
    req0_waddr = a0; req0_iolen = l0;
    req1_waddr = a1; req1_iolen = l1;
    trans_done = td;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cyc(input bit td);
    step(1'b1, 2'b00, '0, '0, '0, '0, td);
  endtask

  task automatic do_reset();
    step(1'b0, 2'b00, '0, '0, '0, '0, 1'b0);
    rst = 1'b1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  int             m_owner;   // -1 when no requester owns the master
  int             m_rr;
  int             m_age;     // 0 in the configuration cycle, 1 afterwards
  bit             m_in_done;
  bit [1:0]       m_pend;
  bit             m_ovf, m_ts;
  bit [1:0]       m_done;
  logic [XAW-1:0] m_haddr [2];
  logic [CW-1:0]  m_hlen  [2];
  logic [XAW-1:0] m_addr;
  logic [CW-1:0]  m_len;

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_age = 0; m_in_done = 0; m_pend = 0;
    m_ovf = 0; m_ts = 0; m_done = 0; m_addr = '0; m_len = '0;
    for (int n = 0; n < 2; n++) begin
      m_haddr[n] = '0; m_hlen[n] = '0;
    end
  endtask

  function automatic logic [63:0] model_out();
    logic [1:0] g;
    g = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    return pack(g, m_ts, m_done, m_ovf, m_addr, m_len);
  endfunction

  task automatic model_edge(input bit [1:0] st, input logic [XAW-1:0] a0, input logic [CW-1:0] l0,
                            input logic [XAW-1:0] a1, input logic [CW-1:0] l1, input bit td);
    bit [1:0] clr;
    int       who;
    clr = 2'b00;
    if (m_owner >= 0 && m_in_done) clr[m_owner] = 1'b1;
    m_ts = 0;
    m_done = 2'b00;
    if (m_owner < 0) begin
      if (m_pend != 0) begin
        who = m_pend[m_rr] ? m_rr : 1 - m_rr;
        m_owner = who; m_age = 0;
        m_addr = m_haddr[who]; m_len = m_hlen[who];
      end
    end else if (m_in_done) begin
      m_rr = 1 - m_owner; m_owner = -1; m_in_done = 0;
    end else if (m_age == 0) begin
      m_age = 1; m_ts = 1;
    end else if (td) begin
      m_in_done = 1; m_done[m_owner] = 1'b1;
    end
    for (int n = 0; n < 2; n++) begin
      if (st[n]) begin
        if (m_pend[n] && !clr[n]) m_ovf = 1;
        else begin
          m_haddr[n] = (n == 1) ? a1 : a0;
          m_hlen[n]  = (n == 1) ? l1 : l0;
        end
      end
    end
    m_pend = (m_pend & ~clr) | st;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit             r;
    bit [1:0]       st;
    logic [XAW-1:0] a0;
    logic [CW-1:0]  l0;
    logic [XAW-1:0] a1;
    logic [CW-1:0]  l1;
    bit             td;
    logic [63:0]    exp;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit r, input bit [1:0] st, input logic [XAW-1:0] a0, input logic [CW-1:0] l0,
                     input logic [XAW-1:0] a1, input logic [CW-1:0] l1, input bit td,
                     input logic [1:0] g, input logic ts, input logic [1:0] d, input logic o,
                     input logic [XAW-1:0] a, input logic [CW-1:0] l);
    vec_t v;
    v.r = r; v.st = st; v.a0 = a0; v.l0 = l0; v.a1 = a1; v.l1 = l1; v.td = td;
    v.exp = pack(g, ts, d, o, a, l);
    vt.push_back(v);
  endtask

  initial begin
    // Single request, stray trans_done in IDLE, reset, simultaneous requests.
    add(1, 2'b01, 32'h1000, 16'd14, 0, 0, 0,  2'b00, 0, 2'b00, 0, 32'h0,    16'd0);
    add(1, 2'b00, 0, 0, 0, 0, 0,              2'b01, 0, 2'b00, 0, 32'h1000, 16'd14);
    add(1, 2'b00, 0, 0, 0, 0, 0,              2'b01, 1, 2'b00, 0, 32'h1000, 16'd14);
    add(1, 2'b00, 0, 0, 0, 0, 0,              2'b01, 0, 2'b00, 0, 32'h1000, 16'd14);
    add(1, 2'b00, 0, 0, 0, 0, 1,              2'b01, 0, 2'b01, 0, 32'h1000, 16'd14);
    add(1, 2'b00, 0, 0, 0, 0, 0,              2'b00, 0, 2'b00, 0, 32'h1000, 16'd14);
    add(1, 2'b00, 0, 0, 0, 0, 1,              2'b00, 0, 2'b00, 0, 32'h1000, 16'd14);
    add(1, 2'b00, 0, 0, 0, 0, 1,              2'b00, 0, 2'b00, 0, 32'h1000, 16'd14);
    add(0, 2'b00, 0, 0, 0, 0, 0,              2'b00, 0, 2'b00, 0, 32'h0,    16'd0);
    add(1, 2'b11, 32'h2000, 16'd3, 32'h3000, 16'd5, 0, 2'b00, 0, 2'b00, 0, 32'h0, 16'd0);
    add(1, 2'b00, 0, 0, 0, 0, 0,              2'b01, 0, 2'b00, 0, 32'h2000, 16'd3);
    add(1, 2'b00, 0, 0, 0, 0, 0,              2'b01, 1, 2'b00, 0, 32'h2000, 16'd3);
    add(1, 2'b00, 0, 0, 0, 0, 1,              2'b01, 0, 2'b01, 0, 32'h2000, 16'd3);
    add(1, 2'b00, 0, 0, 0, 0, 0,              2'b00, 0, 2'b00, 0, 32'h2000, 16'd3);
    add(1, 2'b00, 0, 0, 0, 0, 0,              2'b10, 0, 2'b00, 0, 32'h3000, 16'd5);
    add(1, 2'b00, 0, 0, 0, 0, 0,              2'b10, 1, 2'b00, 0, 32'h3000, 16'd5);
    add(1, 2'b00, 0, 0, 0, 0, 1,              2'b10, 0, 2'b10, 0, 32'h3000, 16'd5);
    add(1, 2'b00, 0, 0, 0, 0, 0,              2'b00, 0, 2'b00, 0, 32'h3000, 16'd5);
    add(1, 2'b11, 32'h4000, 16'd1, 32'h5000, 16'd2, 0, 2'b00, 0, 2'b00, 0, 32'h3000, 16'd5);
    add(1, 2'b00, 0, 0, 0, 0, 0,              2'b01, 0, 2'b00, 0, 32'h4000, 16'd1);

    // Reset state.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", dut_out(), 64'd0);
    rst = 1'b1;

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].st, vt[i].a0, vt[i].l0, vt[i].a1, vt[i].l1, vt[i].td);
      check($sformatf("vec%0d", i), dut_out(), vt[i].exp);
    end

    // Overflow: second req1_start while pending keeps the first parameters.
    do_reset();
    step(1'b1, 2'b10, '0, '0, 32'h6000, 16'd7, 1'b0);
    step(1'b1, 2'b10, '0, '0, 32'h7777, 16'd9, 1'b0);
    check("ovf_config", dut_out(), pack(2'b10, 0, 2'b00, 1, 32'h6000, 16'd7));
    idle_cyc(1'b0);
    check("ovf_trans_start", dut_out(), pack(2'b10, 1, 2'b00, 1, 32'h6000, 16'd7));
    idle_cyc(1'b1);
    check("ovf_done", dut_out(), pack(2'b10, 0, 2'b10, 1, 32'h6000, 16'd7));
    idle_cyc(1'b0);
    idle_cyc(1'b0);
    check("ovf_sticky_no_rerun", dut_out(), pack(2'b00, 0, 2'b00, 1, 32'h6000, 16'd7));

    // Set wins: req0_start during req0's DONE cycle is a fresh request.
    do_reset();
    step(1'b1, 2'b01, 32'h8000, 16'd4, '0, '0, 1'b0);
    idle_cyc(1'b0);
    idle_cyc(1'b0);
    idle_cyc(1'b1);
    check("setwin_done", dut_out(), pack(2'b01, 0, 2'b01, 0, 32'h8000, 16'd4));
    step(1'b1, 2'b01, 32'h9000, 16'd6, '0, '0, 1'b0);
    check("setwin_idle", dut_out(), pack(2'b00, 0, 2'b00, 0, 32'h8000, 16'd4));
    idle_cyc(1'b0);
    check("setwin_config", dut_out(), pack(2'b01, 0, 2'b00, 0, 32'h9000, 16'd6));
    idle_cyc(1'b0);
    check("setwin_trans_start", dut_out(), pack(2'b01, 1, 2'b00, 0, 32'h9000, 16'd6));
    idle_cyc(1'b1);
    idle_cyc(1'b0);

    // Reset mid-TRANS: outputs clear at once, later trans_done is ignored.
    do_reset();
    step(1'b1, 2'b01, 32'hA000, 16'd8, '0, '0, 1'b0);
    idle_cyc(1'b0);
    idle_cyc(1'b0);
    check("midrst_in_trans", dut_out(), pack(2'b01, 1, 2'b00, 0, 32'hA000, 16'd8));
    rst = 1'b0;
    #1;
    check("midrst_async_clear", dut_out(), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle_cyc(1'b1);
    check("midrst_no_done", dut_out(), 64'd0);
    idle_cyc(1'b0);
    idle_cyc(1'b0);
    check("midrst_stays_idle", dut_out(), 64'd0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit             r, td;
      bit [1:0]       st;
      logic [XAW-1:0] a0, a1;
      logic [CW-1:0]  l0, l1;
      check("random", dut_out(), model_out());
      r  = ($urandom_range(0, 399) != 0);
      st = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      td = ($urandom_range(0, 2) == 0);
      a0 = $urandom; a1 = $urandom;
      l0 = CW'($urandom); l1 = CW'($urandom);
      if (r) model_edge(st, a0, l0, a1, l1, td);
      else model_reset();
      step(r, st, a0, l0, a1, l1, td);
    end
    check("random_final", dut_out(), model_out());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wmst_arbiter.md
WMST_ARBITER -- requirements
Module: wmst_arbiter

Interface
REQ-001 SHALL have parameter XAW, default 32, external byte address width.
REQ-002 SHALL have parameter CW, default 16, transfer length width in words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports req0_start and req1_start, input, 1 each, one-cycle request pulse from store controller 0 or 1.
REQ-006 SHALL have ports req0_waddr and req1_waddr, input, XAW each, byte address, sampled with the matching start pulse.
REQ-007 SHALL have ports req0_iolen and req1_iolen, input, CW each, word length, sampled with the matching start pulse.
REQ-008 SHALL have ports req0_done and req1_done, output, 1 each, one-cycle completion pulse to the requester.
REQ-009 SHALL have port grant, output, 2, one-hot owner of the write master and store-FIFO mux select; 2'b00 when idle.
REQ-010 SHALL have port trans_start, output, 1, one-cycle start pulse to the Avalon write master.
REQ-011 SHALL have ports param_waddr (output, XAW) and param_iolen (output, CW), registered transfer parameters.
REQ-012 SHALL have port trans_done, input, 1, one-cycle pulse from the write master ending the current transfer.
REQ-013 SHALL have port req_ovf, output, 1, sticky flag: a start pulse arrived while that requester was already pending.

Function
REQ-014 SHALL, on reqN_start, set pending[N] and latch reqN_waddr and reqN_iolen into per-requester holding registers.
REQ-015 SHALL ignore reqN_start while pending[N] is set, keep the held parameters, and set req_ovf.
REQ-016 SHALL implement states IDLE, CONFIG, TRANS and DONE.
REQ-017 SHALL go IDLE->CONFIG when any pending bit is set; choose the requester under round-robin: priority pointer rr, pending[rr] wins, otherwise the other requester.
REQ-018 SHALL, in the IDLE->CONFIG cycle, register grant one-hot and load param_waddr and param_iolen from the winner's holding registers.
REQ-019 SHALL go CONFIG->TRANS after exactly one cycle and pulse trans_start for one cycle on entry to TRANS; params are therefore stable one cycle before trans_start.
REQ-020 SHALL stay in TRANS until trans_done=1, then go to DONE; trans_done seen outside TRANS SHALL be ignored.
REQ-021 SHALL, in DONE, pulse reqN_done for the granted requester, clear its pending bit, set rr to the other requester, clear grant, and return to IDLE the next cycle.
REQ-022 SHALL treat reqN_start arriving in the same cycle its pending bit clears as a new accepted request (set wins), without req_ovf.
REQ-023 SHALL accept simultaneous req0_start and req1_start, set both pending, and serve them in rr order back-to-back.
REQ-024 SHALL hold param_waddr and param_iolen constant from CONFIG through DONE.
REQ-025 SHALL give a minimum request-to-trans_start latency of 3 cycles: capture, CONFIG, TRANS entry.

Reset
REQ-026 SHALL, while rst=0, force state IDLE, pending=0, rr=0, grant=0, trans_start=0, req0_done=0, req1_done=0, param_waddr=0, param_iolen=0, req_ovf=0.
REQ-027 SHALL drop any in-flight transfer on reset mid-operation; no done pulse after rst is released.

Structure
REQ-028 SHALL place the state encodings (IDLE=2'b00, CONFIG=2'b01, TRANS=2'b10, DONE=2'b11) in the shared accelerator constants package.
REQ-029 SHALL use one sub-module, rr_arb2, a 2-input round-robin grant selector (pending, rr -> one-hot winner).

Verification
REQ-030 SHALL test single request: req0_start, waddr=0x1000, iolen=14 -> grant=01 and params valid in cycle 2, trans_start in cycle 3; trans_done -> req0_done the next cycle.
REQ-031 SHALL test simultaneous requests after reset: req0 and req1 start together (rr=0) -> req0 served first, req1 served with no idle gap beyond the DONE->IDLE->CONFIG cycles, then rr=0.
REQ-032 SHALL test overflow: a second req1_start while req1 is pending, with a different waddr -> original waddr is transferred, req_ovf=1 and it stays set.
REQ-033 SHALL test set-wins: req0_start in the same cycle as req0's DONE -> new req0 transfer starts, req_ovf=0.
REQ-034 SHALL test reset mid-TRANS: rst=0 for 1 cycle -> all outputs 0, state IDLE; a later trans_done produces no done pulse.
REQ-035 SHALL test stray trans_done in IDLE -> no state change and no done pulse.
